// File: rtl/bitrev_pkg.sv
// bitrev_pkg: reversal mode type and a width-generic reference reversal function.
package bitrev_pkg;
   typedef enum logic {REV_FULL, REV_BYTE} rev_mode_t;
   localparam int BITREV_MAX_W = 256;
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] word, input int width, input rev_mode_t mode);
      logic [BITREV_MAX_W-1:0] r;
      r = '0;
      for (int k = 0; k < width; k++)
         r[mode == REV_BYTE ? (k / 8) * 8 + 7 - k % 8 : width - 1 - k] = word[k];
      return r;
   endfunction
endpackage

// File: rtl/bitrev_core.sv
// bitrev_core: combinational full-word or per-byte bit reversal.
module bitrev_core
   import bitrev_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] din,
   input  rev_mode_t             mode,
   output logic [DATA_WIDTH-1:0] dout
);
   logic [DATA_WIDTH-1:0] full_rev, byte_rev;
   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_full
      assign full_rev[k] = din[DATA_WIDTH-1-k];
   end
   if (DATA_WIDTH % 8 == 0) begin : g_byte
      for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_bit
         assign byte_rev[k] = din[(k / 8) * 8 + 7 - k % 8];
      end
   end else begin : g_nobyte
      assign byte_rev = full_rev;
   end
   assign dout = mode == REV_BYTE ? byte_rev : full_rev;
endmodule

// File: rtl/bitrev_arbiter.sv
// bitrev_arbiter: round-robin sharing of one bit-reversal core with a single registered response slot.
// Define BITREV_BYTE_MODE_EN to add the per-requester req_mode port (per-byte reversal).
module bitrev_arbiter
   import bitrev_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   localparam int ID_WIDTH  = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef BITREV_BYTE_MODE_EN
   input  logic [NUM_REQ-1:0]            req_mode,
`endif
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_WIDTH-1:0]           rsp_id
);
   logic [ID_WIDTH-1:0]   last_grant, gnt_id;
   logic                  found, accept;
   logic [DATA_WIDTH-1:0] sel_data, rev_data;
   rev_mode_t             sel_mode;
   int                    idx;
   // Rotating search beginning just past the previous winner
   always_comb begin
      gnt_id = '0;
      found = 1'b0;
      idx = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_grant) + i) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt_id = ID_WIDTH'(idx);
         end
      end
   end
   assign accept    = !reset && found && (!rsp_valid || rsp_ready);
   assign req_ready = accept ? NUM_REQ'(1) << gnt_id : '0;
   assign sel_data  = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
`ifdef BITREV_BYTE_MODE_EN
   if (DATA_WIDTH % 8 != 0) begin : g_width_err
      $error("bitrev_arbiter: DATA_WIDTH must be a multiple of 8 in byte mode");
   end
   assign sel_mode = req_mode[gnt_id] ? REV_BYTE : REV_FULL;
`else
   assign sel_mode = REV_FULL;
`endif
   bitrev_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .din  (sel_data),
      .mode (sel_mode),
      .dout (rev_data)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= '0;
         last_grant <= ID_WIDTH'(NUM_REQ - 1);
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_data   <= rev_data;
         rsp_id     <= gnt_id;
         last_grant <= gnt_id;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bitrev_arbiter.sv
// tb_bitrev_arbiter: directed vectors with hand-computed reversals for bitrev_arbiter (4 x 32-bit).
module tb_bitrev_arbiter;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_data = '0;
`ifdef BITREV_BYTE_MODE_EN
   logic [3:0]   req_mode = '0;
`endif
   logic [3:0]   req_ready;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [31:0]  rsp_data;
   logic [1:0]   rsp_id;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [31:0]  exp_rev [4];
   int           order [6];

   bitrev_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef BITREV_BYTE_MODE_EN
      .req_mode  (req_mode),
`endif
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req_data[0*32 +: 32] = 32'h0000_0001; exp_rev[0] = 32'h8000_0000;
      req_data[1*32 +: 32] = 32'h0000_00F0; exp_rev[1] = 32'h0F00_0000;
      req_data[2*32 +: 32] = 32'h1234_5678; exp_rev[2] = 32'h1E6A_2C48;
      req_data[3*32 +: 32] = 32'hFFFF_0000; exp_rev[3] = 32'h0000_FFFF;
      order = '{0, 1, 2, 3, 0, 1};
      // reset state, with requests pending to prove ready is held low
      req_valid = 4'b1111;
      tick(); tick();
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_valid", 32'(rsp_valid), 32'h0);
      check("rst_data", rsp_data, 32'h0);
      check("rst_id", 32'(rsp_id), 32'h0);
      // 1: single request
      @(negedge clk);
      reset = 1'b0; req_valid = 4'b0001;
      #1 check("t1_ready", 32'(req_ready), 32'h1);
      tick();
      check("t1_valid", 32'(rsp_valid), 32'h1);
      check("t1_data", rsp_data, 32'h8000_0000);
      check("t1_id", 32'(rsp_id), 32'h0);
      // 2: all requesting after a fresh reset
      @(negedge clk);
      reset = 1'b1; req_valid = 4'b0000;
      tick();
      @(negedge clk);
      reset = 1'b0; req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1 check($sformatf("t2_ready%0d", i), 32'(req_ready), 32'h1 << order[i]);
         tick();
         check($sformatf("t2_valid%0d", i), 32'(rsp_valid), 32'h1);
         check($sformatf("t2_id%0d", i), 32'(rsp_id), 32'(order[i]));
         check($sformatf("t2_data%0d", i), rsp_data, exp_rev[order[i]]);
         @(negedge clk);
      end
      // 3: backpressure
      req_data[2*32 +: 32] = 32'h0102_0408; exp_rev[2] = 32'h1020_4080;
      req_valid = 4'b0100;
      #1 check("t3_ready", 32'(req_ready), 32'h4);
      tick();
      check("t3_data", rsp_data, 32'h1020_4080);
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("t3_stall_ready%0d", i), 32'(req_ready), 32'h0);
         tick();
         check($sformatf("t3_stall_valid%0d", i), 32'(rsp_valid), 32'h1);
         check($sformatf("t3_stall_data%0d", i), rsp_data, 32'h1020_4080);
         check($sformatf("t3_stall_id%0d", i), 32'(rsp_id), 32'h2);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 check("t3_release_ready", 32'(req_ready), 32'h8);
      tick();
      check("t3_release_id", 32'(rsp_id), 32'h3);
      check("t3_release_data", rsp_data, 32'h0000_FFFF);
      // 4: drain and accept in the same cycle
      @(negedge clk);
      req_valid = 4'b0100;
      #1 check("t4_ready", 32'(req_ready), 32'h4);
      tick();
      check("t4_valid", 32'(rsp_valid), 32'h1);
      check("t4_id", 32'(rsp_id), 32'h2);
      check("t4_data", rsp_data, 32'h1020_4080);
      // drain with no new accept: data and id hold
      @(negedge clk);
      req_valid = 4'b0000;
      tick();
      check("drain_valid", 32'(rsp_valid), 32'h0);
      check("drain_data", rsp_data, 32'h1020_4080);
      check("drain_id", 32'(rsp_id), 32'h2);
      // 5: reset while full and stalled
      @(negedge clk);
      req_valid = 4'b0001;
      #1 check("t5_ready", 32'(req_ready), 32'h1);
      tick();
      check("t5_valid", 32'(rsp_valid), 32'h1);
      @(negedge clk);
      req_valid = 4'b0000; rsp_ready = 1'b0; reset = 1'b1;
      tick();
      check("t5_rst_valid", 32'(rsp_valid), 32'h0);
      check("t5_rst_data", rsp_data, 32'h0);
      @(negedge clk);
      reset = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1010;
      #1 check("t5_ready_after", 32'(req_ready), 32'h2);
      tick();
      check("t5_id_after", 32'(rsp_id), 32'h1);
      check("t5_data_after", rsp_data, 32'h0F00_0000);
`ifdef BITREV_BYTE_MODE_EN
      // 6: byte mode versus full mode on the same word
      @(negedge clk);
      req_valid = 4'b0100; req_mode = 4'b0100;
      tick();
      check("t6_byte", rsp_data, 32'h8040_2010);
      @(negedge clk);
      req_mode = 4'b0000;
      tick();
      check("t6_full", rsp_data, 32'h1020_4080);
`endif
      @(negedge clk);
      req_valid = 4'b0000;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
